// File: rtl/fir_tap_scheduler.sv
// Tap scheduler for a 40-tap transposed FIR: arbitrates host coefficient writes against
// 10-tap read bursts on 4 SRAM banks. Optional macro FIR_COEFF_MIRROR_EN: symmetric loading.
module fir_tap_scheduler #(
  parameter int NUM_BANK      = 4,
  parameter int TAPS_PER_BANK = 10,
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 4
) (
  input  logic                iClk_12M,
  input  logic                iRst,
  input  logic                iEnSample_600k,
  input  logic                iUpdateReq,
  input  logic                iCoeffValid,
  input  logic [5:0]          iCoeffIdx,
  input  logic [DATA_W-1:0]   iCoeffData,
  input  logic                iDropClr,
  output logic                oUpdateAck,
  output logic                oCoeffReady,
  output logic [NUM_BANK-1:0] oCsnRam,
  output logic [NUM_BANK-1:0] oWrnRam,
  output logic [ADDR_W-1:0]   oAddrRam,
  output logic [DATA_W-1:0]   oWrDtRam,
  output logic                oAccClr,
  output logic                oEnMul,
  output logic [3:0]          oTapSel,
  output logic                oEnAcc,
  output logic                oEnSum,
  output logic                oBusy,
  output logic                oSampleDrop,
  output logic                oIdxErr,
  output logic [2:0]          dbg_state
);

  localparam int BANK_W     = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int TOTAL_TAPS = NUM_BANK * TAPS_PER_BANK;
`ifdef FIR_COEFF_MIRROR_EN
  localparam int IDX_LIMIT  = TOTAL_TAPS / 2;
`else
  localparam int IDX_LIMIT  = TOTAL_TAPS;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UPDATE = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_SUM    = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] cnt;
  logic       hs;
  logic       idx_ok;
  logic       wr_pend;

  // Bank/offset split of a global tap index by range compare against bank bases.
  function automatic logic [BANK_W-1:0] bank_of(input logic [5:0] idx);
    bank_of = '0;
    for (int b = 1; b < NUM_BANK; b++)
      if (idx >= 6'(b * TAPS_PER_BANK)) bank_of = BANK_W'(b);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [5:0] idx);
    logic [5:0] base;
    base = '0;
    for (int b = 1; b < NUM_BANK; b++)
      if (idx >= 6'(b * TAPS_PER_BANK)) base = 6'(b * TAPS_PER_BANK);
    addr_of = ADDR_W'(idx - base);
  endfunction

  function automatic logic [NUM_BANK-1:0] sel_of(input logic [BANK_W-1:0] bank);
    sel_of = ~(NUM_BANK'(1) << bank);
  endfunction

  // Handshake: a coefficient transfers on any cycle where iCoeffValid and oCoeffReady are
  // both high while in UPDATE; the host holds idx/data stable while valid is high.
  assign hs        = (state == S_UPDATE) && iCoeffValid && oCoeffReady;
  assign idx_ok    = iCoeffIdx < 6'(IDX_LIMIT);
  assign dbg_state = state;

`ifdef FIR_COEFF_MIRROR_EN
  logic              mir_pend;
  logic              mir_ok;
  logic [5:0]        mir_idx;
  logic [DATA_W-1:0] mir_data;
  assign wr_pend = mir_pend;
`else
  assign wr_pend = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (iEnSample_600k)  state_nxt = S_READ;
        else if (iUpdateReq) state_nxt = S_UPDATE;
      end
      S_UPDATE: if (!iUpdateReq && !hs && !wr_pend) state_nxt = S_IDLE;
      S_READ:   if (cnt == 4'(TAPS_PER_BANK - 1)) state_nxt = S_DRAIN;
      S_DRAIN:  if (cnt == 4'd1) state_nxt = S_SUM;
      S_SUM:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      oUpdateAck  <= 1'b0;
      oCoeffReady <= 1'b0;
      oCsnRam     <= '1;
      oWrnRam     <= '1;
      oAddrRam    <= '0;
      oWrDtRam    <= '0;
      oAccClr     <= 1'b0;
      oEnMul      <= 1'b0;
      oTapSel     <= '0;
      oEnAcc      <= 1'b0;
      oEnSum      <= 1'b0;
      oBusy       <= 1'b0;
      oSampleDrop <= 1'b0;
      oIdxErr     <= 1'b0;
`ifdef FIR_COEFF_MIRROR_EN
      mir_pend    <= 1'b0;
      mir_ok      <= 1'b0;
      mir_idx     <= '0;
      mir_data    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      oBusy      <= (state_nxt != S_IDLE);
      oUpdateAck <= (state_nxt == S_UPDATE);
`ifdef FIR_COEFF_MIRROR_EN
      oCoeffReady <= (state_nxt == S_UPDATE) && iUpdateReq && !hs && !mir_pend;
`else
      oCoeffReady <= (state_nxt == S_UPDATE) && iUpdateReq;
`endif
      oCsnRam  <= '1;
      oWrnRam  <= '1;
      oWrDtRam <= '0;
      oAccClr  <= 1'b0;
      oEnSum   <= 1'b0;
      // Read data lands one cycle after the address; multiplier and accumulator follow it.
      oEnMul   <= (state == S_READ);
      oEnAcc   <= oEnMul;
      if (state == S_READ) oTapSel <= 4'(oAddrRam);

      case (state)
        S_IDLE: begin
          if (iEnSample_600k) begin
            oCsnRam  <= '0;
            oAddrRam <= '0;
            oAccClr  <= 1'b1;
            cnt      <= '0;
          end
        end
        S_READ: begin
          if (cnt != 4'(TAPS_PER_BANK - 1)) begin
            oCsnRam  <= '0;
            oAddrRam <= oAddrRam + 1'b1;
            cnt      <= cnt + 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (cnt == 4'd1) oEnSum <= 1'b1;
        end
        S_UPDATE: begin
          if (hs && idx_ok) begin
            oCsnRam  <= sel_of(bank_of(iCoeffIdx));
            oWrnRam  <= sel_of(bank_of(iCoeffIdx));
            oAddrRam <= addr_of(iCoeffIdx);
            oWrDtRam <= iCoeffData;
          end
        end
        default: ;
      endcase

`ifdef FIR_COEFF_MIRROR_EN
      // Second half of a symmetric pair goes out the cycle after the primary write.
      mir_pend <= hs;
      if (hs) begin
        mir_ok   <= idx_ok;
        mir_idx  <= 6'(TOTAL_TAPS - 1) - iCoeffIdx;
        mir_data <= iCoeffData;
      end
      if (mir_pend && mir_ok) begin
        oCsnRam  <= sel_of(bank_of(mir_idx));
        oWrnRam  <= sel_of(bank_of(mir_idx));
        oAddrRam <= addr_of(mir_idx);
        oWrDtRam <= mir_data;
      end
`endif

      oSampleDrop <= (iEnSample_600k && (state != S_IDLE)) || (oSampleDrop && !iDropClr);
      oIdxErr     <= (hs && !idx_ok) || (oIdxErr && !iDropClr);
    end
  end

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Bench for fir_tap_scheduler: event and write scoreboards fed by the stimulus tasks,
// drained by a negedge monitor. Covers FIR_COEFF_MIRROR_EN when defined.
module tb_fir_tap_scheduler;

  logic        clk = 1'b0;
  logic        iRst;
  logic        iEnSample_600k;
  logic        iUpdateReq;
  logic        iCoeffValid;
  logic [5:0]  iCoeffIdx;
  logic [15:0] iCoeffData;
  logic        iDropClr;
  logic        oUpdateAck;
  logic        oCoeffReady;
  logic [3:0]  oCsnRam;
  logic [3:0]  oWrnRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic        oAccClr;
  logic        oEnMul;
  logic [3:0]  oTapSel;
  logic        oEnAcc;
  logic        oEnSum;
  logic        oBusy;
  logic        oSampleDrop;
  logic        oIdxErr;
  logic [2:0]  dbg_state;

  fir_tap_scheduler dut (
    .iClk_12M(clk), .iRst(iRst), .iEnSample_600k(iEnSample_600k),
    .iUpdateReq(iUpdateReq), .iCoeffValid(iCoeffValid), .iCoeffIdx(iCoeffIdx),
    .iCoeffData(iCoeffData), .iDropClr(iDropClr), .oUpdateAck(oUpdateAck),
    .oCoeffReady(oCoeffReady), .oCsnRam(oCsnRam), .oWrnRam(oWrnRam),
    .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam), .oAccClr(oAccClr), .oEnMul(oEnMul),
    .oTapSel(oTapSel), .oEnAcc(oEnAcc), .oEnSum(oEnSum), .oBusy(oBusy),
    .oSampleDrop(oSampleDrop), .oIdxErr(oIdxErr), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // events: {cycle[15:0], kind[3:0], value[11:0]}; kinds 1 read, 2 accclr, 3 mul, 4 acc, 5 sum
  logic [31:0] exp_q[$];
  // writes: {cycle[15:0], csn[3:0], wrn[3:0], addr[3:0], data[15:0]}
  logic [43:0] wr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int kind, input int val);
    exp_q.push_back({16'(c), 4'(kind), 12'(val)});
  endtask

  task automatic push_wr(input int c, input int bank, input int addr, input int data);
    logic [3:0] m;
    m = 4'b0001 << bank;
    m = ~m;
    wr_q.push_back({16'(c), m, m, 4'(addr), 16'(data)});
  endtask

  task automatic obs_ev(input int kind, input int val);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("burst_event", {16'(cyc), 4'(kind), 12'(val)}, e);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic [43:0] w;
      if (oCsnRam == 4'h0 && oWrnRam == 4'hF) obs_ev(1, int'(oAddrRam));
      if (oAccClr) obs_ev(2, 0);
      if (oEnMul)  obs_ev(3, int'(oTapSel));
      if (oEnAcc)  obs_ev(4, 0);
      if (oEnSum)  obs_ev(5, 0);
      if (oWrnRam != 4'hF) begin
        w = (wr_q.size() > 0) ? wr_q.pop_front() : '1;
        check("bank_write", {16'(cyc), oCsnRam, oWrnRam, oAddrRam, oWrDtRam}, w);
      end else begin
        check("wrdt_idle", oWrDtRam, 0);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // upto = number of burst cycles expected to appear (0: strobe expected to be ignored)
  task automatic pulse_strobe(input int upto, input bit with_req, output int t);
    @(negedge clk);
    iEnSample_600k = 1'b1;
    if (with_req) iUpdateReq = 1'b1;
    t = cyc;
    for (int c = 1; c <= upto; c++) begin
      if (c <= 10)            push_ev(t + c, 1, c - 1);
      if (c == 1)             push_ev(t + c, 2, 0);
      if (c >= 2 && c <= 11)  push_ev(t + c, 3, c - 2);
      if (c >= 3 && c <= 12)  push_ev(t + c, 4, 0);
      if (c == 13)            push_ev(t + c, 5, 0);
    end
    @(negedge clk);
    iEnSample_600k = 1'b0;
  endtask

  // b1/b2 < 0 means no write expected in that slot
  task automatic coeff_write(input int idx, input int data, input int b1, input int a1,
                             input int b2, input int a2, output int w);
    int n;
    @(negedge clk);
    iCoeffValid = 1'b1;
    iCoeffIdx   = 6'(idx);
    iCoeffData  = 16'(data);
    n = 0;
    while (!oCoeffReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", oCoeffReady, 1);
    w = cyc;
    if (b1 >= 0) push_wr(w + 1, b1, a1, data);
    if (b2 >= 0) push_wr(w + 2, b2, a2, data);
    @(negedge clk);
    iCoeffValid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_csn_wrn"}, {oCsnRam, oWrnRam}, 8'hFF);
    check({tag, "_addr_dt_tap"}, {oAddrRam, oWrDtRam, oTapSel}, 0);
    check({tag, "_ctrl"}, {oAccClr, oEnMul, oEnAcc, oEnSum, oBusy, oUpdateAck, oCoeffReady}, 0);
    check({tag, "_sticky"}, {oSampleDrop, oIdxErr}, 0);
  endtask

  initial begin
    int t;
    int w;
    iRst = 1'b1; iEnSample_600k = 1'b0; iUpdateReq = 1'b0; iCoeffValid = 1'b0;
    iCoeffIdx = '0; iCoeffData = '0; iDropClr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    iRst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // plain burst
    pulse_strobe(13, 1'b0, t);
    wait_to(t + 13);
    check("busy_at_sum", oBusy, 1);
    wait_to(t + 14);
    check("busy_after_sum", oBusy, 0);

    // strobe and update request together: burst first, then UPDATE
    pulse_strobe(13, 1'b1, t);
    wait_to(t + 14);
    check("ack_deferred", oUpdateAck, 0);
    wait_to(t + 15);
    check("ack_after_burst", {oUpdateAck, oCoeffReady}, 2'b11);

    pulse_strobe(0, 1'b0, t);
    check("drop_in_update", oSampleDrop, 1);
    @(negedge clk); iDropClr = 1'b1;
    @(negedge clk); iDropClr = 1'b0;
    check("drop_cleared", oSampleDrop, 0);

`ifdef FIR_COEFF_MIRROR_EN
    coeff_write(3, 16'h00AA, 0, 3, 3, 6, w);
    check("mirror_ready_w1", oCoeffReady, 0);
    @(negedge clk);
    check("mirror_ready_w2", oCoeffReady, 0);
    @(negedge clk);
    check("mirror_ready_w3", oCoeffReady, 1);
    coeff_write(19, 16'h5A5A, 1, 9, 2, 0, w);
    coeff_write(20, 16'h1111, -1, 0, -1, 0, w);
    check("idx_err_20", oIdxErr, 1);
    repeat (2) @(negedge clk);
`else
    coeff_write(0, 16'h1234, 0, 0, -1, 0, w);
    check("ready_stays_high", oCoeffReady, 1);
    coeff_write(9, 16'h1234, 0, 9, -1, 0, w);
    coeff_write(10, 16'h1234, 1, 0, -1, 0, w);
    coeff_write(25, 16'h1234, 2, 5, -1, 0, w);
    coeff_write(39, 16'hBEEF, 3, 9, -1, 0, w);
    check("idx_err_clear", oIdxErr, 0);
    coeff_write(45, 16'h7777, -1, 0, -1, 0, w);
    check("idx_err_45", oIdxErr, 1);
`endif
    @(negedge clk); iDropClr = 1'b1;
    @(negedge clk); iDropClr = 1'b0;
    check("idx_err_cleared", oIdxErr, 0);

    iUpdateReq = 1'b0;
    repeat (3) @(negedge clk);
    check("update_exit", {oUpdateAck, oCoeffReady, oBusy}, 0);

    // strobe during READ is dropped, no second burst
    pulse_strobe(13, 1'b0, t);
    wait_to(t + 5);
    pulse_strobe(0, 1'b0, w);
    check("drop_in_read", oSampleDrop, 1);
    wait_to(t + 16);

    // reset mid-burst abandons it
    pulse_strobe(6, 1'b0, t);
    wait_to(t + 6);
    iRst = 1'b1;
    @(negedge clk);
    check_reset("midburst");
    iRst = 1'b0;
    wait_to(t + 18);

    pulse_strobe(13, 1'b0, t);
    wait_to(t + 14);
    check("busy_final", oBusy, 0);
    repeat (3) @(negedge clk);

    check("ev_q_drained", exp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
